// File: rtl/uart_rx_deser.sv
// UART receive deserializer with OVERSAMPLE-x oversampling; samples each bit at its
// centre and pushes good bytes downstream with a one-clock rx_done strobe.
module uart_rx_deser #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_n;
  logic                 rx_meta, rx_s;
  logic [TICK_W-1:0]    tick_q, tick_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n, data_n;
  logic                 done_n, ferr_n;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_n;
      tick_q    <= tick_n;
      bit_q     <= bit_n;
      shift_q   <= shift_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
    end
  end

  // rx_done is a plain push with no back-pressure: the consumer must take
  // rx_data in the cycle rx_done is high or lose it.
  always_comb begin
    state_n = state_q;
    tick_n  = b_tick ? tick_q + TICK_W'(1) : tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    data_n  = rx_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state_q)
      IDLE: begin
        tick_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (b_tick && tick_q == TICK_MID) begin
          tick_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (b_tick && tick_q == TICK_LAST) begin
          tick_n  = '0;
          shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_n   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (b_tick && tick_q == TICK_LAST) begin
          tick_n  = '0;
          state_n = IDLE;
          if (rx_s) begin
            data_n = shift_q;
            done_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: frames are described at byte level, the expected
// outcome of each frame is queued and compared against the strobes seen.
module tb_uart_rx_deser;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int TP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          b_tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_done, rx_busy, frame_err;

  int total = 0;
  int bad = 0;
  int n_done = 0, n_err = 0;
  int n_exp_done = 0, n_exp_err = 0;
  logic          tick_en = 1'b1;
  logic [DB:0]   exp_q[$];
  logic [DB:0]   ev;
  logic [DB-1:0] last_good = '0;
  logic          prev_strobe = 1'b0;

  uart_rx_deser #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  // clock and tick generation
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TP - 1) @(negedge clk);
      b_tick = tick_en;
      @(negedge clk);
      b_tick = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < n * TP * 4 + 1000) begin
      @(posedge clk);
      guard++;
      if (b_tick) seen++;
    end
    if (seen < n) check("tick_timeout", seen, n);
  endtask

  task automatic send_bit(input logic v, input int n);
    @(negedge clk);
    rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok, input logic gate);
    send_bit(1'b0, OS);
    check("busy_in_frame", rx_busy, 1);
    for (int i = 0; i < DB; i++) begin
      if (gate && i == 4) begin
        @(negedge clk);
        rx = d[i];
        wait_ticks(OS / 2);
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        check("busy_gated", rx_busy, 1);
        tick_en = 1'b1;
        wait_ticks(OS / 2);
      end else begin
        send_bit(d[i], OS);
      end
    end
    if (stop_ok) begin
      exp_q.push_back({1'b0, d});
      n_exp_done++;
      send_bit(1'b1, OS);
    end else begin
      exp_q.push_back({1'b1, {DB{1'b0}}});
      n_exp_err++;
      send_bit(1'b0, OS / 2 + 2);
      send_bit(1'b1, OS / 2 - 2);
    end
  endtask

  // scoreboard: every strobe must match the oldest expected frame outcome
  always @(negedge clk) begin
    if (rst) begin
      last_good <= '0;
    end else if (rx_done || frame_err) begin
      check("both_strobes", {31'd0, rx_done & frame_err}, 0);
      check("strobe_width", {31'd0, prev_strobe}, 0);
      if (rx_done) n_done++;
      if (frame_err) n_err++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, rx_done, frame_err}, 0);
      end else begin
        ev = exp_q.pop_front();
        check("strobe_kind", frame_err, ev[DB]);
        if (ev[DB]) begin
          check("data_hold", rx_data, last_good);
        end else begin
          check("rx_data", rx_data, ev[DB-1:0]);
          last_good <= ev[DB-1:0];
        end
      end
    end
    prev_strobe <= rx_done | frame_err;
  end

  initial begin
    logic [DB-1:0] d;
    logic ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    wait_ticks(20);

    send_frame(8'hA5, 1'b1, 1'b0);
    send_bit(1'b1, OS);
    check("idle_busy_a5", rx_busy, 0);
    check("hold_a5", rx_data, 8'hA5);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_bit(1'b1, OS);
    check("hold_3c", rx_data, 8'h3C);

    send_bit(1'b0, 3);
    send_bit(1'b1, OS);
    check("glitch_busy", rx_busy, 0);

    send_frame(8'h55, 1'b0, 1'b0);
    send_bit(1'b1, OS);
    check("ferr_hold_3c", rx_data, 8'h3C);
    check("ferr_busy", rx_busy, 0);

    // reset in the middle of 0x81, after four data bits
    send_bit(1'b0, OS);
    d = 8'h81;
    for (int i = 0; i < 4; i++) send_bit(d[i], OS);
    check("busy_pre_rst", rx_busy, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rx_data", rx_data, 0);
    check("arst_rx_done", rx_done, 0);
    check("arst_rx_busy", rx_busy, 0);
    check("arst_frame_err", frame_err, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(OS);
    send_frame(8'h42, 1'b1, 1'b0);
    send_bit(1'b1, OS);
    check("post_rst_42", rx_data, 8'h42);

    send_frame(8'hC6, 1'b1, 1'b1);
    send_bit(1'b1, OS);
    check("gated_c6", rx_data, 8'hC6);

    for (int k = 0; k < 10; k++) begin
      d = DB'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, 1'b0);
      send_bit(1'b1, $urandom_range(0, 12));
    end

    send_bit(1'b1, 2 * OS);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, n_exp_done);
    check("err_count", n_err, n_exp_err);
    check("final_busy", rx_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
